pet_mem_ctl: RTL and testbench

Parametrised memory controller for the PET core. It decodes CPU addresses into RAM, video RAM, I/O and ROM selects, and muxes read data from synchronous memories. It also implements the 8096-style expansion-RAM control register at $FFF0. It arbitrates a single shared memory port between the CPU and a DMA loader (PRG/ROM injection) using a request/acknowledge handshake. It sits between the CPU core and the RAM/VRAM/ROM/I/O blocks inside the PET hardware wrapper.

---
 rtl/pet_mem_pkg.sv | 41 ++++
 rtl/pet_dma_arb.sv | 55 +++++
 rtl/pet_mem_ctl.sv | 164 ++++++++++++++++
 tb/tb_pet_mem_ctl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pet_mem_pkg.sv
// Shared types and address-map constants for the PET memory controller.
// Expansion banking is compiled in only when PET_EXPRAM_EN is defined.
package pet_mem_pkg;

    typedef enum logic [2:0] {
        RAM,
        NONE,
        VRAM,
        ROM,
        IO
    } region_t;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_WAIT,
        DMA_ACC,
        DMA_DONE
    } dma_state_t;

    localparam int CTRL_WP_LO     = 0;
    localparam int CTRL_WP_HI     = 1;
    localparam int CTRL_BANK_LO   = 2;
    localparam int CTRL_BANK_HI   = 3;
    localparam int CTRL_KEEP_VRAM = 5;
    localparam int CTRL_KEEP_IO   = 6;
    localparam int CTRL_EN        = 7;

    localparam logic [15:0] CTRL_ADDR = 16'hFFF0;
    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam logic [15:0] VRAM_END  = 16'h8FFF;
    localparam logic [15:0] IO_BASE   = 16'hE800;
    localparam logic [15:0] IO_END    = 16'hEFFF;
    localparam logic [16:0] EXP_BASE  = 17'h08000;

    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/pet_dma_arb.sv
// DMA slot arbiter: grants the shared memory port to DMA in the clock
// right after a CPU cycle, and pulses dma_ack when the access is done.
module pet_dma_arb
    import pet_mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ce_1m,
    input  logic dma_req,
    output logic dma_slot,
    output logic dma_ack
);

    dma_state_t state_q;
    logic       ce_prev_q;
    logic       slot_q;
    logic       ack_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DMA_IDLE;
            ce_prev_q <= 1'b0;
            slot_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            ce_prev_q <= ce_1m;
            slot_q    <= 1'b0;
            ack_q     <= 1'b0;
            case (state_q)
                DMA_IDLE: if (dma_req) state_q <= DMA_WAIT;
                DMA_WAIT: begin
                    // Falling edge of ce_1m marks the start of the CPU gap.
                    if (!ce_1m && ce_prev_q) begin
                        state_q <= DMA_ACC;
                        slot_q  <= 1'b1;
                    end
                end
                DMA_ACC: begin
                    if (ce_1m) begin
                        state_q <= DMA_WAIT;
                    end else begin
                        state_q <= DMA_DONE;
                        ack_q   <= 1'b1;
                    end
                end
                DMA_DONE: state_q <= DMA_IDLE;
                default:  state_q <= DMA_IDLE;
            endcase
        end
    end

    assign dma_slot = slot_q;
    assign dma_ack  = ack_q;

endmodule

// File: rtl/pet_mem_ctl.sv
// PET memory controller: address decode, read mux, $FFF0 expansion
// register (PET_EXPRAM_EN) and CPU/DMA sharing of the memory port.
module pet_mem_ctl
    import pet_mem_pkg::*;
#(
    parameter int RAM_KB  = 32,
    parameter int VRAM_AW = 10,
    parameter int ROM_AW  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce_1m,
    input  logic [15:0]        cpu_addr,
    input  logic [7:0]         cpu_din,
    input  logic               cpu_we,
    output logic [7:0]         cpu_dout,
    output logic [16:0]        mem_addr,
    output logic [7:0]         mem_din,
    output logic               ram_we,
    output logic               vram_we,
    output logic               rom_we,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [7:0]         ram_q,
    input  logic [7:0]         vram_q,
    input  logic [7:0]         rom_q,
    input  logic [7:0]         io_q,
    output logic               io_sel,
    input  logic               dma_req,
    input  logic               dma_we,
    input  logic [16:0]        dma_addr,
    input  logic [7:0]         dma_din,
    output logic [7:0]         dma_dout,
    output logic               dma_ack,
    output logic [7:0]         ctrl_reg
);

    localparam logic [16:0] RAM_TOP  = 17'(RAM_KB * 1024);
    localparam logic [16:0] ROM_MASK = 17'((1 << ROM_AW) - 1);

    logic [7:0]  ctrl_v;
    region_t     cpu_rgn;
    logic [16:0] cpu_phys;
    logic        cpu_wp;
    logic [1:0]  bank;
    logic        cpu_wr;
    logic        dma_slot;
    logic        dma_go;
    logic        dma_ram_ok;
    logic [7:0]  dma_rd;
    region_t     sel_q;
    logic        rd_vld_q;
    logic [7:0]  dma_dout_q;

    assign cpu_wr = ce_1m & cpu_we & ~reset;

`ifdef PET_EXPRAM_EN
    localparam logic EXP_BUILD = 1'b1;
    logic [7:0] ctrl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ctrl_q <= 8'h00;
        else if (cpu_wr && cpu_addr == CTRL_ADDR)
            ctrl_q <= cpu_din;
    end
    assign ctrl_v = ctrl_q;
`else
    localparam logic EXP_BUILD = 1'b0;
    assign ctrl_v = 8'h00;
`endif

    always_comb begin
        cpu_rgn  = ROM;
        cpu_phys = {1'b0, cpu_addr};
        cpu_wp   = 1'b0;
        bank     = 2'd0;
        if (!cpu_addr[15]) begin
            cpu_rgn = ({1'b0, cpu_addr} < RAM_TOP) ? RAM : NONE;
        end else begin
            if (in_range(cpu_addr, VRAM_BASE, VRAM_END)) begin
                cpu_rgn = VRAM;
            end else if (in_range(cpu_addr, IO_BASE, IO_END)) begin
                cpu_rgn = IO;
            end else begin
                cpu_phys = {1'b0, cpu_addr} & ROM_MASK;
            end
            if (ctrl_v[CTRL_EN]) begin
                // Lower half picks bank 0/2, upper half bank 1/3.
                bank   = cpu_addr[14] ? {ctrl_v[CTRL_BANK_HI], 1'b1}
                                      : {ctrl_v[CTRL_BANK_LO], 1'b0};
                cpu_wp = cpu_addr[14] ? ctrl_v[CTRL_WP_HI] : ctrl_v[CTRL_WP_LO];
                if (!((cpu_rgn == VRAM && ctrl_v[CTRL_KEEP_VRAM]) ||
                      (cpu_rgn == IO && ctrl_v[CTRL_KEEP_IO]))) begin
                    cpu_rgn  = RAM;
                    cpu_phys = EXP_BASE + {1'b0, bank, 14'h0} + {3'b000, cpu_addr[13:0]};
                end
            end
        end
    end

    pet_dma_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .ce_1m    (ce_1m),
        .dma_req  (dma_req),
        .dma_slot (dma_slot),
        .dma_ack  (dma_ack)
    );

    // A CPU cycle landing on the DMA slot takes the port; the arbiter retries.
    assign dma_go     = dma_slot & ~ce_1m;
    assign dma_ram_ok = EXP_BUILD | ~dma_addr[15];
    assign dma_rd     = dma_addr[16] ? rom_q : ram_q;

    always_comb begin
        mem_addr  = cpu_phys;
        mem_din   = cpu_din;
        vram_addr = cpu_addr[VRAM_AW-1:0];
        ram_we    = cpu_wr & (cpu_rgn == RAM) & ~cpu_wp;
        vram_we   = cpu_wr & (cpu_rgn == VRAM);
        rom_we    = 1'b0;
        if (dma_go) begin
            mem_din  = dma_din;
            vram_we  = 1'b0;
            mem_addr = dma_addr[16] ? (dma_addr & ROM_MASK) : dma_addr;
            ram_we   = dma_we & ~dma_addr[16] & dma_ram_ok;
            rom_we   = dma_we & dma_addr[16];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q      <= RAM;
            rd_vld_q   <= 1'b0;
            dma_dout_q <= 8'h00;
        end else begin
            if (ce_1m) begin
                sel_q    <= cpu_rgn;
                rd_vld_q <= 1'b1;
            end
            if (dma_ack)
                dma_dout_q <= dma_rd;
        end
    end

    // Memory data arrives one clock after the address, matching sel_q.
    always_comb begin
        cpu_dout = 8'h00;
        if (rd_vld_q) begin
            case (sel_q)
                RAM:     cpu_dout = ram_q;
                VRAM:    cpu_dout = vram_q;
                ROM:     cpu_dout = rom_q;
                IO:      cpu_dout = io_q;
                default: cpu_dout = 8'hFF;
            endcase
        end
    end

    assign dma_dout = dma_ack ? dma_rd : dma_dout_q;
    assign io_sel   = ce_1m & (cpu_rgn == IO);
    assign ctrl_reg = ctrl_v;

endmodule

// File: tb/tb_pet_mem_ctl.sv
// Directed bench for pet_mem_ctl (RAM_KB=16); expansion vectors are
// compiled in when PET_EXPRAM_EN is defined.
module tb_pet_mem_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_1m = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_dout;
    logic [16:0] mem_addr;
    logic [7:0]  mem_din;
    logic        ram_we, vram_we, rom_we;
    logic [9:0]  vram_addr;
    logic [7:0]  ram_q = 8'hA5;
    logic [7:0]  vram_q = 8'h5A;
    logic [7:0]  rom_q = 8'hC3;
    logic [7:0]  io_q = 8'h3C;
    logic        io_sel;
    logic        dma_req = 1'b0;
    logic        dma_we = 1'b0;
    logic [16:0] dma_addr = '0;
    logic [7:0]  dma_din = '0;
    logic [7:0]  dma_dout;
    logic        dma_ack;
    logic [7:0]  ctrl_reg;

    pet_mem_ctl #(.RAM_KB(16), .VRAM_AW(10), .ROM_AW(15)) dut (
        .clk(clk), .reset(reset), .ce_1m(ce_1m), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .ram_we(ram_we),
        .vram_we(vram_we), .rom_we(rom_we), .vram_addr(vram_addr),
        .ram_q(ram_q), .vram_q(vram_q), .rom_q(rom_q), .io_q(io_q),
        .io_sel(io_sel), .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_din(dma_din), .dma_dout(dma_dout),
        .dma_ack(dma_ack), .ctrl_reg(ctrl_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  din;
        logic        we;
        logic        e_ram_we;
        logic        e_vram_we;
        logic        e_io;
        logic [16:0] e_ma;
        logic [9:0]  e_va;
        logic [7:0]  e_dout;
        logic [7:0]  e_ctrl;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic vec_t mk(input logic [15:0] a, input logic [7:0] d, input logic w,
                                input logic rw, input logic vw, input logic io,
                                input logic [16:0] ma, input logic [9:0] va,
                                input logic [7:0] dout, input logic [7:0] ctl);
        vec_t v;
        v.addr = a; v.din = d; v.we = w; v.e_ram_we = rw; v.e_vram_we = vw;
        v.e_io = io; v.e_ma = ma; v.e_va = va; v.e_dout = dout; v.e_ctrl = ctl;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int i);
        @(negedge clk);
        ce_1m = 1'b1; cpu_addr = v.addr; cpu_we = v.we; cpu_din = v.din;
        #1;
        check($sformatf("v%0d ram_we", i), ram_we, v.e_ram_we);
        check($sformatf("v%0d vram_we", i), vram_we, v.e_vram_we);
        check($sformatf("v%0d rom_we", i), rom_we, 1'b0);
        check($sformatf("v%0d io_sel", i), io_sel, v.e_io);
        check($sformatf("v%0d mem_addr", i), mem_addr, v.e_ma);
        check($sformatf("v%0d vram_addr", i), vram_addr, v.e_va);
        if (v.we) check($sformatf("v%0d mem_din", i), mem_din, v.din);
        @(negedge clk);
        ce_1m = 1'b0; cpu_we = 1'b0;
        cpu_addr = (v.e_dout == 8'h3C) ? 16'h0000 : 16'hE810;
        #1;
        check($sformatf("v%0d cpu_dout", i), cpu_dout, v.e_dout);
        check($sformatf("v%0d ctrl_reg", i), ctrl_reg, v.e_ctrl);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_dma(input string nm, input logic we, input logic [16:0] a,
                           input logic [7:0] d, input int e_rom, input int e_ram,
                           input logic [16:0] e_ma, input logic chk_dout,
                           input logic [7:0] e_dout);
        int rom_n = 0, ram_n = 0, ack_n = 0, ack_c = -1, bad_ce = 0;
        logic [16:0] ma = '0;
        logic [7:0]  md = '0;
        logic acked = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            ce_1m = (c % 8 == 0); cpu_addr = 16'h0000; cpu_we = 1'b0;
            dma_req = (c >= 1) && !acked; dma_we = we; dma_addr = a; dma_din = d;
            #1;
            if (rom_we || ram_we) begin
                if (rom_we) rom_n++;
                if (ram_we) ram_n++;
                if (ce_1m) bad_ce++;
                ma = mem_addr; md = mem_din;
            end
            if (dma_ack) begin
                ack_n++;
                if (ack_c < 0) ack_c = c;
                acked = 1'b1;
                if (chk_dout) check({nm, " dout@ack"}, dma_dout, e_dout);
            end
            if (c % 8 == 1) check({nm, " cpu_rd"}, cpu_dout, 8'hA5);
        end
        dma_req = 1'b0;
        check({nm, " ack_count"}, ack_n, 1);
        check({nm, " latency>=3"}, (ack_c - 1) >= 3, 1'b1);
        check({nm, " rom_we_count"}, rom_n, e_rom);
        check({nm, " ram_we_count"}, ram_n, e_ram);
        check({nm, " we_during_ce"}, bad_ce, 0);
        if (e_rom + e_ram > 0) begin
            check({nm, " mem_addr"}, ma, e_ma);
            check({nm, " mem_din"}, md, d);
        end
        if (chk_dout) check({nm, " dout_held"}, dma_dout, e_dout);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " cpu_dout"}, cpu_dout, 8'h00);
        check({nm, " dma_dout"}, dma_dout, 8'h00);
        check({nm, " dma_ack"}, dma_ack, 1'b0);
        check({nm, " ctrl_reg"}, ctrl_reg, 8'h00);
        check({nm, " ram_we"}, ram_we, 1'b0);
        check({nm, " vram_we"}, vram_we, 1'b0);
        check({nm, " rom_we"}, rom_we, 1'b0);
    endtask

    initial begin
        int ack_seen;
        vecs.push_back(mk(16'h0000, 8'h00, 0, 0, 0, 0, 17'h00000, 10'h000, 8'hA5, 8'h00));
        vecs.push_back(mk(16'h5000, 8'h55, 1, 0, 0, 0, 17'h05000, 10'h000, 8'hFF, 8'h00));
        vecs.push_back(mk(16'h5000, 8'h00, 0, 0, 0, 0, 17'h05000, 10'h000, 8'hFF, 8'h00));
        vecs.push_back(mk(16'h1234, 8'h12, 1, 1, 0, 0, 17'h01234, 10'h234, 8'hA5, 8'h00));
        vecs.push_back(mk(16'h3FFF, 8'h00, 0, 0, 0, 0, 17'h03FFF, 10'h3FF, 8'hA5, 8'h00));
        vecs.push_back(mk(16'h7FFF, 8'h00, 0, 0, 0, 0, 17'h07FFF, 10'h3FF, 8'hFF, 8'h00));
        vecs.push_back(mk(16'h8010, 8'h00, 0, 0, 0, 0, 17'h08010, 10'h010, 8'h5A, 8'h00));
        vecs.push_back(mk(16'h8C05, 8'h99, 1, 0, 1, 0, 17'h08C05, 10'h005, 8'h5A, 8'h00));
        vecs.push_back(mk(16'hE810, 8'h00, 0, 0, 0, 1, 17'h0E810, 10'h010, 8'h3C, 8'h00));
        vecs.push_back(mk(16'h9000, 8'h00, 0, 0, 0, 0, 17'h01000, 10'h000, 8'hC3, 8'h00));
        vecs.push_back(mk(16'hF000, 8'h77, 1, 0, 0, 0, 17'h07000, 10'h000, 8'hC3, 8'h00));
`ifdef PET_EXPRAM_EN
        vecs.push_back(mk(16'hFFF0, 8'h84, 1, 0, 0, 0, 17'h07FF0, 10'h3F0, 8'hC3, 8'h84));
        vecs.push_back(mk(16'h9000, 8'h3C, 1, 1, 0, 0, 17'h11000, 10'h000, 8'hA5, 8'h84));
        vecs.push_back(mk(16'hFFF0, 8'h85, 1, 1, 0, 0, 17'h0FFF0, 10'h3F0, 8'hA5, 8'h85));
        vecs.push_back(mk(16'h9000, 8'h3C, 1, 0, 0, 0, 17'h11000, 10'h000, 8'hA5, 8'h85));
        vecs.push_back(mk(16'hFFF0, 8'hE0, 1, 1, 0, 0, 17'h0FFF0, 10'h3F0, 8'hA5, 8'hE0));
        vecs.push_back(mk(16'h8010, 8'h00, 0, 0, 0, 0, 17'h08010, 10'h010, 8'h5A, 8'hE0));
        vecs.push_back(mk(16'hE810, 8'h00, 0, 0, 0, 1, 17'h0E810, 10'h010, 8'h3C, 8'hE0));
        vecs.push_back(mk(16'hC000, 8'h00, 0, 0, 0, 0, 17'h0C000, 10'h000, 8'hA5, 8'hE0));
        vecs.push_back(mk(16'h9000, 8'h00, 0, 0, 0, 0, 17'h09000, 10'h000, 8'hA5, 8'hE0));
`else
        vecs.push_back(mk(16'hFFF0, 8'h84, 1, 0, 0, 0, 17'h07FF0, 10'h3F0, 8'hC3, 8'h00));
`endif

        // Reset with an active CPU write strobe.
        ce_1m = 1'b1; cpu_we = 1'b1; cpu_din = 8'h11;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0; ce_1m = 1'b0; cpu_we = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        run_dma("dma_rom_wr", 1'b1, 17'h10000, 8'h4C, 1, 0, 17'h00000, 1'b0, 8'h00);
        run_dma("dma_ram_rd", 1'b0, 17'h00123, 8'h00, 0, 0, 17'h00000, 1'b1, 8'hA5);
`ifdef PET_EXPRAM_EN
        run_dma("dma_hi_wr", 1'b1, 17'h09000, 8'h55, 0, 1, 17'h09000, 1'b0, 8'h00);
`else
        run_dma("dma_hi_wr", 1'b1, 17'h09000, 8'h55, 0, 0, 17'h00000, 1'b0, 8'h00);
`endif

        // Reset while the DMA request sits in WAIT.
        @(negedge clk); ce_1m = 1'b1; cpu_addr = 16'h0000;
        @(negedge clk); ce_1m = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 17'h00123;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        check_reset_outputs("rst_wait");
        @(negedge clk); reset = 1'b0; dma_req = 1'b0;
        ack_seen = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            ce_1m = (c % 8 == 0);
            #1;
            if (dma_ack || ram_we || rom_we) ack_seen++;
        end
        check("rst_wait no_ack", ack_seen, 0);
        run_dma("dma_after_rst", 1'b0, 17'h00123, 8'h00, 0, 0, 17'h00000, 1'b1, 8'hA5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
